// File: rtl/skolem_chk_pkg.sv
// Shared types and closed-form helpers for the lshr Skolem sweep checker.
// Helpers take an explicit width so one definition serves every W up to MAX_W.
package skolem_chk_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 2 * DEF_W + 1;
  localparam int MAX_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_SWEEP = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Invertibility condition for x >>u s == t: ((t << s) >>u s) == t at width w.
  function automatic logic lshr_ic(input logic [MAX_W-1:0] s,
                                   input logic [MAX_W-1:0] t,
                                   input int               w);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    return ((((t << s) & mask) >> s) == (t & mask));
  endfunction

  function automatic logic lshr_ok(input logic [MAX_W-1:0] x,
                                   input logic [MAX_W-1:0] s,
                                   input logic [MAX_W-1:0] t,
                                   input int               w);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    return (((x & mask) >> s) == (t & mask));
  endfunction

endpackage

// File: rtl/skolem_lshr_eval.sv
// Combinational evaluator: invertibility condition and Skolem candidate check
// for one (s, t, x) triple.
module skolem_lshr_eval
  import skolem_chk_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] t_i,
  input  logic [W-1:0] x_i,
  output logic         ic_o,
  output logic         ok_o
);

  assign ic_o = lshr_ic(MAX_W'(s_i), MAX_W'(t_i), W);
  assign ok_o = lshr_ok(MAX_W'(x_i), MAX_W'(s_i), MAX_W'(t_i), W);

endmodule

// File: rtl/skolem_lshr_checker.sv
// Sweeps every (s,t) pair through an external lshr Skolem block and checks x.
// Define SKOLEM_CHK_BRUTE_IC_EN to add a brute-force IC cross-check (SWEEP state).
module skolem_lshr_checker
  import skolem_chk_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 2 * W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [W-1:0]     s_out,
  output logic [W-1:0]     t_out,
  input  logic [W-1:0]     x_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] valid_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [W-1:0]     first_fail_s,
  output logic [W-1:0]     first_fail_t,
  output logic [W-1:0]     first_fail_x,
  output logic             ic_err
);

  localparam int               IDX_W    = 2 * W;
  localparam int               SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0] valid_q, valid_d, fail_q, fail_d;
  logic             ff_vld_q, ff_vld_d;
  logic [W-1:0]     ff_s_q, ff_s_d, ff_t_q, ff_t_d, ff_x_q, ff_x_d;
  logic [W-1:0]     cur_s, cur_t;
  logic             ic_cf, x_ok, ic_use;

  // s/t come straight from the pair index, which only moves on entry to APPLY.
  assign cur_s = idx_q[W-1:0];
  assign cur_t = idx_q[IDX_W-1:W];

  skolem_lshr_eval #(.W(W)) u_eval (
    .s_i  (cur_s),
    .t_i  (cur_t),
    .x_i  (x_in),
    .ic_o (ic_cf),
    .ok_o (x_ok)
  );

`ifdef SKOLEM_CHK_BRUTE_IC_EN
  localparam logic [W-1:0] XT_LAST = '1;
  logic [W-1:0] xt_q, xt_d;
  logic         exists_q, exists_d, ic_err_q, ic_err_d;
  assign ic_use = exists_q;
  assign ic_err = ic_err_q;
`else
  assign ic_use = ic_cf;
  assign ic_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = done_q;
    valid_d  = valid_q;
    fail_d   = fail_q;
    ff_vld_d = ff_vld_q;
    ff_s_d   = ff_s_q;
    ff_t_d   = ff_t_q;
    ff_x_d   = ff_x_q;
`ifdef SKOLEM_CHK_BRUTE_IC_EN
    xt_d     = xt_q;
    exists_d = exists_q;
    ic_err_d = ic_err_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // The status flip to done lags DONE entry by one edge.
        if (state_q == ST_DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        if (start) begin
          state_d  = ST_APPLY;
          idx_d    = '0;
          settle_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          valid_d  = '0;
          fail_d   = '0;
          ff_vld_d = 1'b0;
          ff_s_d   = '0;
          ff_t_d   = '0;
          ff_x_d   = '0;
`ifdef SKOLEM_CHK_BRUTE_IC_EN
          ic_err_d = 1'b0;
`endif
        end
      end
      ST_APPLY: begin
`ifdef SKOLEM_CHK_BRUTE_IC_EN
        xt_d     = '0;
        exists_d = 1'b0;
`endif
        if (settle_q == SET_LAST) begin
          settle_d = '0;
`ifdef SKOLEM_CHK_BRUTE_IC_EN
          state_d  = ST_SWEEP;
`else
          state_d  = ST_CHECK;
`endif
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
`ifdef SKOLEM_CHK_BRUTE_IC_EN
      ST_SWEEP: begin
        exists_d = exists_q | lshr_ok(MAX_W'(xt_q), MAX_W'(cur_s), MAX_W'(cur_t), W);
        xt_d     = xt_q + W'(1);
        if (xt_q == XT_LAST) state_d = ST_CHECK;
      end
`endif
      ST_CHECK: begin
        if (ic_use) begin
          valid_d = valid_q + CNT_W'(1);
          if (!x_ok) begin
            fail_d = fail_q + CNT_W'(1);
            if (!ff_vld_q) begin
              ff_vld_d = 1'b1;
              ff_s_d   = cur_s;
              ff_t_d   = cur_t;
              ff_x_d   = x_in;
            end
          end
        end
`ifdef SKOLEM_CHK_BRUTE_IC_EN
        if (exists_q != ic_cf) ic_err_d = 1'b1;
`endif
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= '0;
      fail_q   <= '0;
      ff_vld_q <= 1'b0;
      ff_s_q   <= '0;
      ff_t_q   <= '0;
      ff_x_q   <= '0;
`ifdef SKOLEM_CHK_BRUTE_IC_EN
      xt_q     <= '0;
      exists_q <= 1'b0;
      ic_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      fail_q   <= fail_d;
      ff_vld_q <= ff_vld_d;
      ff_s_q   <= ff_s_d;
      ff_t_q   <= ff_t_d;
      ff_x_q   <= ff_x_d;
`ifdef SKOLEM_CHK_BRUTE_IC_EN
      xt_q     <= xt_d;
      exists_q <= exists_d;
      ic_err_q <= ic_err_d;
`endif
    end
  end

  assign s_out          = cur_s;
  assign t_out          = cur_t;
  assign busy           = busy_q;
  assign done           = done_q;
  assign valid_cnt      = valid_q;
  assign fail_cnt       = fail_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_s   = ff_s_q;
  assign first_fail_t   = ff_t_q;
  assign first_fail_x   = ff_x_q;

endmodule

// File: tb/tb_skolem_lshr_checker.sv
// Bench for skolem_lshr_checker: directed sweeps with correct, stuck, random and
// delayed Skolem models, checked against a brute-force reference model.
module tb_skolem_lshr_checker;

  localparam int W     = 4;
  localparam int CNT_W = 2 * W + 1;
  localparam int NPAIR = 256;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start3;

  logic [W-1:0]     s1, t1, x1, ffs1, fft1, ffx1;
  logic [W-1:0]     s3, t3, x3, ffs3, fft3, ffx3;
  logic             busy1, done1, ffv1, icerr1;
  logic             busy3, done3, ffv3, icerr3;
  logic [CNT_W-1:0] valid1, fail1, valid3, fail3;
  logic [W-1:0]     d1_q, d2_q;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;   // 0: x = t << s, 1: x stuck at 0, 2: table rnd_x
  int rnd_x [NPAIR];
  int lat;

  always #5 clk = ~clk;

  // Skolem block models: combinational for dut1, two-cycle delayed for dut3.
  assign x1 = (mode == 0) ? W'(t1 << s1) : (mode == 1) ? '0 : W'(rnd_x[{t1, s1}]);

  always @(posedge clk) begin
    d1_q <= W'(t3 << s3);
    d2_q <= d1_q;
  end
  assign x3 = d2_q;

  skolem_lshr_checker #(.W(W), .SETTLE(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s_out(s1), .t_out(t1), .x_in(x1),
    .busy(busy1), .done(done1), .valid_cnt(valid1), .fail_cnt(fail1),
    .first_fail_vld(ffv1), .first_fail_s(ffs1), .first_fail_t(fft1),
    .first_fail_x(ffx1), .ic_err(icerr1)
  );

  skolem_lshr_checker #(.W(W), .SETTLE(3), .CNT_W(CNT_W)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .s_out(s3), .t_out(t3), .x_in(x3),
    .busy(busy3), .done(done3), .valid_cnt(valid3), .fail_cnt(fail3),
    .first_fail_vld(ffv3), .first_fail_s(ffs3), .first_fail_t(fft3),
    .first_fail_x(ffx3), .ic_err(icerr3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int xval(input int m, input int s, input int t);
    if (m == 0) return (t << s) & 15;
    if (m == 1) return 0;
    return rnd_x[t * 16 + s];
  endfunction

  // Reference: IC is "some 4-bit x shifts right by s onto t", found by search.
  task automatic model(input int m, output int v, output int f, output int fv,
                       output int fs, output int ft, output int fx);
    v = 0; f = 0; fv = 0; fs = 0; ft = 0; fx = 0;
    for (int t = 0; t < 16; t++) begin
      for (int s = 0; s < 16; s++) begin
        int x;
        bit ic;
        x  = xval(m, s, t);
        ic = 1'b0;
        for (int c = 0; c < 16; c++) if ((c >> s) == t) ic = 1'b1;
        if (ic) begin
          v++;
          if ((x >> s) != t) begin
            f++;
            if (fv == 0) begin
              fv = 1; fs = s; ft = t; fx = x;
            end
          end
        end
      end
    end
  endtask

  task automatic check_results(input int sel, input string tag);
    int v, f, fv, fs, ft, fx;
    model(mode, v, f, fv, fs, ft, fx);
    if (sel == 0) begin
      check({tag, "_valid"}, valid1, v);
      check({tag, "_fail"}, fail1, f);
      check({tag, "_ffv"}, ffv1, fv);
      check({tag, "_ffs"}, ffs1, fs);
      check({tag, "_fft"}, fft1, ft);
      check({tag, "_ffx"}, ffx1, fx);
      check({tag, "_icerr"}, icerr1, 0);
      check({tag, "_busy_end"}, busy1, 0);
    end else begin
      check({tag, "_valid"}, valid3, v);
      check({tag, "_fail"}, fail3, f);
      check({tag, "_ffv"}, ffv3, fv);
      check({tag, "_busy_end"}, busy3, 0);
    end
  endtask

  // Start a sweep, optionally poke start again at edge 'poke', count edges to done.
  task automatic run_sweep(input int sel, input int budget, input int poke, output int l);
    @(negedge clk);
    if (sel == 0) start1 = 1'b1; else start3 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    check("busy_after_start", (sel == 0) ? busy1 : busy3, 1);
    check("done_after_start", (sel == 0) ? done1 : done3, 0);
    l = budget;
    for (int n = 1; n <= budget; n++) begin
      if (sel == 0) start1 = (n == poke);
      @(posedge clk); #1;
      if ((sel == 0 && done1) || (sel == 1 && done3)) begin
        l = n;
        break;
      end
    end
    start1 = 1'b0;
  endtask

  task automatic check_zero1(input string tag);
    check({tag, "_s"}, s1, 0);
    check({tag, "_t"}, t1, 0);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_done"}, done1, 0);
    check({tag, "_valid"}, valid1, 0);
    check({tag, "_fail"}, fail1, 0);
    check({tag, "_ffv"}, ffv1, 0);
    check({tag, "_ffsx"}, {ffs1, fft1, ffx1}, 0);
    check({tag, "_icerr"}, icerr1, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    for (int i = 0; i < NPAIR; i++) rnd_x[i] = 0;
    #12;
    check_zero1("reset");
    check("reset3_done", done3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero1("idle_no_start");

    // Correct Skolem model.
    mode = 0;
    run_sweep(0, 600, -1, lat);
    check("lat_correct", lat, 513);
    check_results(0, "correct");
    check("correct_s_hold", s1, 15);
    check("correct_t_hold", t1, 15);
    repeat (5) @(posedge clk);
    #1;
    check("done_level_held", done1, 1);

    // Stuck-at-zero model; expectations also pinned as absolute numbers.
    mode = 1;
    run_sweep(0, 600, -1, lat);
    check("lat_stuck", lat, 513);
    check_results(0, "stuck");
    check("stuck_valid_abs", valid1, 42);
    check("stuck_fail_abs", fail1, 26);
    check("stuck_first_st", {ffs1, fft1, ffx1}, {4'd0, 4'd1, 4'd0});

    // Randomised models: each pair either correct or an arbitrary x.
    mode = 2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NPAIR; i++)
        rnd_x[i] = ($urandom_range(0, 1) == 1) ? (((i / 16) << (i % 16)) & 15)
                                                : int'($urandom_range(0, 15));
      run_sweep(0, 600, -1, lat);
      check("lat_random", lat, 513);
      check_results(0, "random");
    end

    // start pulsed mid-sweep must be ignored.
    run_sweep(0, 600, 100, lat);
    check("lat_start_busy", lat, 513);
    check_results(0, "start_busy");

    // Asynchronous reset mid-sweep, then a clean full sweep.
    mode = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (199) @(posedge clk);
    #1;
    check("midsweep_busy", busy1, 1);
    rst_n = 1'b0;
    #2;
    check_zero1("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 600, -1, lat);
    check("lat_after_reset", lat, 513);
    check_results(0, "after_reset");

    // SETTLE=3 with a two-cycle-delayed correct Skolem block.
    run_sweep(1, 1100, -1, lat);
    check("lat_settle3", lat, 1025);
    check_results(1, "settle3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
